shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
Shares one LSL/LSR shift datapath between two independent requesters, for example the ALU issue path and the address-generation path.
- Each requester has a valid/ready request port.
- The block arbitrates round-robin, performs the shift, and returns the result through a single registered output with a valid/ready handshake, tagged with the requester ID.
- The output stage is one entry deep, giving fixed 1-cycle latency and full throughput when the consumer keeps out_ready high.

Parameters:
WIDTH, 32, data width in bits
SHIFT, 5, shift-amount width in bits (shift range 0..2^SHIFT-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a shift pending
req0_ready  output  1  requester 0 accepted this cycle
req0_opcode  input  4  requester 0 operation
req0_data  input  WIDTH  requester 0 operand
req0_shift  input  SHIFT  requester 0 shift amount
req1_valid  input  1  requester 1 has a shift pending
req1_ready  output  1  requester 1 accepted this cycle
req1_opcode  input  4  requester 1 operation
req1_data  input  WIDTH  requester 1 operand
req1_shift  input  SHIFT  requester 1 shift amount
out_valid  output  1  out_data/out_id hold a result
out_ready  input  1  consumer takes the result this cycle
out_data  output  WIDTH  shifted result
out_id  output  1  requester that issued the result

Behaviour:
- Opcodes:
  - 4'b1010 is LSL, zero fill.
  - 4'b1011 is LSR, zero fill.
  - Any other opcode passes the operand through unchanged.
  - Shift amount 0 returns the operand unchanged.
  - The result is truncated to WIDTH bits.
- Slot free: can_accept = !out_valid || out_ready. The held output register is free, or is being drained in the same cycle.
- Grant is combinational from valids, can_accept and last_grant:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - can_accept low: no grant.
- reqN_ready = can_accept && grant==N && reqN_valid. At most one ready is high per cycle.
- A handshake is reqN_valid && reqN_ready. On it:
  - out_data <= shift result, out_id <= N, out_valid <= 1 on the next edge (1-cycle latency).
  - last_grant <= N.
- out_valid && out_ready with no new handshake: out_valid <= 0. out_data and out_id keep their last values.
- Simultaneous drain and accept: the new result replaces the old in the same edge, so out_valid stays 1 (back-to-back throughput of 1/cycle).
- Backpressure:
  - out_valid && !out_ready: both readies are 0.
  - out_data and out_id are held stable.
- Starvation-free: a requester holding valid is granted within 2 accepted transactions.
- Requesters must hold opcode/data/shift stable while valid && !ready. The block samples operands only on the handshake cycle.
- Reset (asynchronous, any time):
  - out_valid=0, out_data=0, out_id=0.
  - last_grant=1, so requester 0 wins the first contention.
  - An in-flight result is discarded.
  - Readies go low immediately while reset is high.
- State view:
  - EMPTY (out_valid=0) to FULL on a handshake.
  - FULL to EMPTY on a drain without a handshake.
  - FULL to FULL on a drain plus handshake, or on a stall.

Optional Feature:
Macro SHIFTER_ARB_ASR_EN.
- Defined: opcode 4'b1100 performs an arithmetic shift right that sign-fills from data bit WIDTH-1.
- Undefined: 4'b1100 falls under the pass-through default.
- All other behaviour and ports are identical in both builds.

Test Plan:
- Single request: req0 valid, opcode 1010, data 32'h0000_0001, shift 4, out_ready=1.
  - Required: req0_ready=1 in cycle 0.
  - Required: next cycle out_valid=1, out_data=32'h0000_0010, out_id=0.
- Contention after reset: both valid in the same cycle, req1 opcode 1011, data 32'h8000_0000, shift 31.
  - Required: req0 granted first; req1 granted in the next cycle.
  - Required: second result out_data=32'h0000_0001, out_id=1.
- Sustained contention: both valid for 6 cycles, out_ready=1.
  - Required: out_id sequence 0,1,0,1,0,1, with out_valid continuously high after the first cycle.
- Backpressure: result held with out_ready=0 for 3 cycles while req1 is valid.
  - Required: req1_ready=0 and out_data unchanged during the stall.
  - Required: when out_ready=1, req1 is accepted in the same cycle and its result appears on the next cycle.
- Pass-through and reset:
  - Opcode 4'b0000, data 32'hDEAD_BEEF, shift 7 gives out_data=32'hDEAD_BEEF.
  - Asserting reset mid-stall gives out_valid=0 immediately.
  - After reset release, contention grants req0 first.
- ASR (SHIFTER_ARB_ASR_EN defined), opcode 1100, data 32'hF000_0000, shift 4:
  - Defined: out_data=32'hFF00_0000.
  - Undefined: out_data=32'hF000_0000.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one LSL/LSR shifter between two requesters, with a one-deep registered output.
// Optional build macro SHIFTER_ARB_ASR_EN adds opcode 4'b1100 as an arithmetic shift right.
module shifter_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHIFT-1:0] req0_shift,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHIFT-1:0] req1_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id
);

    localparam logic [3:0] OP_LSL = 4'b1010;
    localparam logic [3:0] OP_LSR = 4'b1011;
`ifdef SHIFTER_ARB_ASR_EN
    localparam logic [3:0] OP_ASR = 4'b1100;
`endif

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             can_accept;
    logic             hs;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic [SHIFT-1:0] sel_shift;
    logic [WIDTH-1:0] shift_res;

    assign out_valid = (state == FULL);

    // Arbitration: the requester that did not win last time takes a tie; readies drop while in reset.
    always_comb begin
        can_accept = !reset && ((state == EMPTY) || out_ready);
        grant      = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = can_accept && req0_valid && !grant;
        req1_ready = can_accept && req1_valid && grant;
        hs         = req0_ready || req1_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (hs) state_nxt = FULL;
            FULL:    if (out_ready && !hs) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Shared shift datapath, fed by the granted requester.
    always_comb begin
        sel_op    = grant ? req1_opcode : req0_opcode;
        sel_data  = grant ? req1_data   : req0_data;
        sel_shift = grant ? req1_shift  : req0_shift;
        shift_res = sel_data;
        case (sel_op)
            OP_LSL:  shift_res = sel_data << sel_shift;
            OP_LSR:  shift_res = sel_data >> sel_shift;
`ifdef SHIFTER_ARB_ASR_EN
            OP_ASR:  shift_res = WIDTH'($signed(sel_data) >>> sel_shift);
`endif
            default: shift_res = sel_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (hs) begin
                out_data   <= shift_res;
                out_id     <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: expected results queued on each handshake, compared while held on the output.
module tb_shifter_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHIFT = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_opcode, req1_opcode;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [SHIFT-1:0] req0_shift, req1_shift;
    logic             out_valid, out_ready, out_id;
    logic [WIDTH-1:0] out_data;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    shifter_arbiter #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_data(req0_data), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_data(req1_data), .req1_shift(req1_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference shifter; sign fill built from a mask rather than a signed shift.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [3:0] op, input logic [WIDTH-1:0] d,
                                                   input logic [SHIFT-1:0] sh);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (op)
            4'b1010: return d << sh;
            4'b1011: return d >> sh;
`ifdef SHIFTER_ARB_ASR_EN
            4'b1100: return (d >> sh) | (d[WIDTH-1] ? ~(ones >> sh) : '0);
`endif
            default: return d;
        endcase
    endfunction

    // One clock: check readies and the held output at the falling edge, update the scoreboard.
    task automatic step(input logic e0, input logic e1);
        @(negedge clk);
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
            check("out_data", out_data, sb[0].data);
            check("out_id", 32'(out_id), 32'(sb[0].id));
            if (out_ready) void'(sb.pop_front());
        end
        if (req0_valid && req0_ready)
            sb.push_back('{1'b0, ref_shift(req0_opcode, req0_data, req0_shift)});
        if (req1_valid && req1_ready)
            sb.push_back('{1'b1, ref_shift(req1_opcode, req1_data, req1_shift)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        reset = 1'b0;
    endtask

    task automatic set0(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] d, input logic [SHIFT-1:0] sh);
        req0_valid = v; req0_opcode = op; req0_data = d; req0_shift = sh;
    endtask

    task automatic set1(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] d, input logic [SHIFT-1:0] sh);
        req1_valid = v; req1_opcode = op; req1_data = d; req1_shift = sh;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        set0(1'b0, 4'b0, '0, '0);
        set1(1'b0, 4'b0, '0, '0);
        @(posedge clk);
        #1;
        do_reset();

        // Single request
        set0(1'b1, 4'b1010, 32'h0000_0001, 5'd4);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        check("single_data", out_data, 32'h0000_0010);
        step(1'b0, 1'b0);

        // Contention after reset: req0 first, then req1
        do_reset();
        set0(1'b1, 4'b1011, 32'h0000_00F0, 5'd4);
        set1(1'b1, 4'b1011, 32'h8000_0000, 5'd31);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        step(1'b0, 1'b1);
        req1_valid = 1'b0;
        check("cont_data", out_data, 32'h0000_0001);
        check("cont_id", 32'(out_id), 32'd1);
        step(1'b0, 1'b0);

        // Sustained contention: alternating grants, output stays valid
        set0(1'b1, 4'b1010, $urandom, 5'($urandom_range(0, 31)));
        set1(1'b1, 4'b1011, $urandom, 5'($urandom_range(0, 31)));
        for (int i = 0; i < 6; i++) begin
            step(i % 2 == 0, i % 2 == 1);
            if (i % 2 == 0) set0(1'b1, 4'($urandom_range(9, 12)), $urandom, 5'($urandom_range(0, 31)));
            else            set1(1'b1, 4'($urandom_range(9, 12)), $urandom, 5'($urandom_range(0, 31)));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Backpressure: held result blocks req1 until the consumer drains
        set0(1'b1, 4'b1010, 32'h0000_00AB, 5'd8);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        out_ready  = 1'b0;
        set1(1'b1, 4'b1010, 32'h0000_0003, 5'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("bp_held_data", out_data, 32'h0000_AB00);
        out_ready = 1'b1;
        step(1'b0, 1'b1);
        req1_valid = 1'b0;
        check("bp_new_data", out_data, 32'h0000_0006);
        step(1'b0, 1'b0);

        // Pass-through, then reset in the middle of a stall
        set0(1'b1, 4'b0000, 32'hDEAD_BEEF, 5'd7);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        out_ready  = 1'b0;
        check("pass_data", out_data, 32'hDEAD_BEEF);
        step(1'b0, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        do_reset();
        out_ready = 1'b1;
        set0(1'b1, 4'b1010, 32'h0000_0001, 5'd31);
        set1(1'b1, 4'b1011, 32'h1234_5678, 5'd0);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
        check("post_rst_id", 32'(out_id), 32'd0);
        step(1'b0, 1'b1);
        req1_valid = 1'b0;
        step(1'b0, 1'b0);

        // Opcode 4'b1100 (ASR when enabled, pass-through otherwise)
        set0(1'b1, 4'b1100, 32'hF000_0000, 5'd4);
        step(1'b1, 1'b0);
        req0_valid = 1'b0;
`ifdef SHIFTER_ARB_ASR_EN
        check("asr_data", out_data, 32'hFF00_0000);
`else
        check("asr_data", out_data, 32'hF000_0000);
`endif
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
